// File: rtl/bishift_pkg.sv
// Shared definitions for the bidirectional serial link (transmitter and receiver sides).
// Optional parity support is selected with BISHIFT_PISO_PARITY_EN in the users of this package.
package bishift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bishift_bit_counter.sv
// Modulo-WIDTH bit counter with clear and terminal-count flag; shared by the TX and RX sides.
module bishift_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(WIDTH - 1));

  // Explicit wrap so non-power-of-two widths still count modulo WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bishift_piso_tx.sv
// Parallel-in serial-out transmitter, MSB- or LSB-first per word, with a done pulse per word.
// Define BISHIFT_PISO_PARITY_EN to append an even-parity bit after each word.
module bishift_piso_tx
  import bishift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             load_fire;
  logic             cnt_en;
  logic             cnt_tc;
`ifdef BISHIFT_PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign sout_valid = busy;
  assign sout       = sout_q;
  assign done       = done_q;
  assign load_fire  = en & load_valid & load_ready;
  assign cnt_en     = en & (state_q == ST_SHIFT);

  bishift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (load_fire),
    .tc  (cnt_tc)
  );

  // The first bit is presented straight from din on the load edge, so shreg
  // always holds the bits still to be sent, pre-aligned to the output end.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    dir_d    = dir_q;
    sout_d   = sout_q;
    done_d   = 1'b0;
`ifdef BISHIFT_PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            state_d = ST_SHIFT;
            dir_d   = dir;
`ifdef BISHIFT_PISO_PARITY_EN
            parity_d = ^din;
`endif
            if (dir == DIR_LSB_FIRST) begin
              sout_d  = din[0];
              shreg_d = {1'b0, din[WIDTH-1:1]};
            end else begin
              sout_d  = din[WIDTH-1];
              shreg_d = {din[WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_tc) begin
`ifdef BISHIFT_PISO_PARITY_EN
            state_d = ST_PAR;
            sout_d  = parity_q;
`else
            state_d = ST_IDLE;
            sout_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else if (dir_q == DIR_LSB_FIRST) begin
            sout_d  = shreg_q[0];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end else begin
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end
        end
`ifdef BISHIFT_PISO_PARITY_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          sout_d  = 1'b0;
          done_d  = 1'b1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      dir_q    <= DIR_MSB_FIRST;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BISHIFT_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      dir_q    <= dir_d;
      sout_q   <= sout_d;
      done_q   <= done_d;
`ifdef BISHIFT_PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_bishift_piso_tx.sv
// Directed bench for bishift_piso_tx (WIDTH=4); follows BISHIFT_PISO_PARITY_EN when defined.
module tb_bishift_piso_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] din = 4'h0;
  logic       dir = 1'b0;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  bishift_piso_tx #(
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .dir        (dir),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one word; seq lists the expected serial bits, seq[3] first.
  task automatic run_word(input string name, input logic [3:0] w, input logic d,
                          input logic [3:0] seq, input logic par, input logic noise);
    load_valid = 1'b1;
    din        = w;
    dir        = d;
    cyc();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({name, "_bit"}, sout, seq[3-i]);
      check({name, "_valid"}, sout_valid, 1'b1);
      check({name, "_busy"}, busy, 1'b1);
      check({name, "_ready"}, load_ready, 1'b0);
      check({name, "_done_low"}, done, 1'b0);
      if (noise) begin
        load_valid = 1'b1;
        din        = (i % 2 == 0) ? 4'h5 : 4'hA;
        dir        = ~dir;
      end
      cyc();
    end
`ifdef BISHIFT_PISO_PARITY_EN
    check({name, "_par"}, sout, par);
    check({name, "_par_valid"}, sout_valid, 1'b1);
    check({name, "_par_done_low"}, done, 1'b0);
    cyc();
`endif
    check({name, "_done"}, done, 1'b1);
    check({name, "_done_valid"}, sout_valid, 1'b0);
    check({name, "_done_ready"}, load_ready, 1'b1);
    check({name, "_done_busy"}, busy, 1'b0);
    load_valid = 1'b0;
    cyc();
    check({name, "_done_once"}, done, 1'b0);
    $display("word %s din=%b dir=%0d par=%0d checked", name, w, d, par);
  endtask

  initial begin
    // Reset held with a pending word that must not be captured.
    rst        = 1'b0;
    load_valid = 1'b1;
    din        = 4'hF;
    @(negedge clk);
    check("rst_sout_in", sout, 1'b0);
    check("rst_busy_in", busy, 1'b0);
    cyc();
    load_valid = 1'b0;
    rst        = 1'b1;
    cyc();
    check("rst_sout", sout, 1'b0);
    check("rst_valid", sout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    $display("reset checked");

    run_word("msb", 4'b1011, 1'b0, 4'b1011, 1'b1, 1'b0);
    run_word("lsb", 4'b1011, 1'b1, 4'b1101, 1'b1, 1'b1);
    run_word("busyload", 4'b0110, 1'b0, 4'b0110, 1'b0, 1'b1);

    // Enable stall after the second bit and again across the final edge.
    load_valid = 1'b1;
    din        = 4'b1100;
    dir        = 1'b0;
    cyc();
    load_valid = 1'b0;
    check("stall_b0", sout, 1'b1);
    cyc();
    check("stall_b1", sout, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold_sout", sout, 1'b1);
      check("stall_hold_valid", sout_valid, 1'b1);
      check("stall_hold_busy", busy, 1'b1);
      check("stall_hold_done", done, 1'b0);
    end
    en = 1'b1;
    cyc();
    check("stall_b2", sout, 1'b0);
    cyc();
    check("stall_b3", sout, 1'b0);
`ifdef BISHIFT_PISO_PARITY_EN
    cyc();
    check("stall_par", sout, 1'b0);
    check("stall_par_valid", sout_valid, 1'b1);
`endif
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("stall_defer_done", done, 1'b0);
      check("stall_defer_busy", busy, 1'b1);
    end
    en = 1'b1;
    cyc();
    check("stall_done", done, 1'b1);
    check("stall_done_valid", sout_valid, 1'b0);
    cyc();
    check("stall_done_once", done, 1'b0);
    $display("stall word 1100 checked");

    // Abort mid-word with reset.
    load_valid = 1'b1;
    din        = 4'b1100;
    dir        = 1'b0;
    cyc();
    load_valid = 1'b0;
    cyc();
    check("abort_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_sout", sout, 1'b0);
    check("abort_valid", sout_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    check("abort_ready", load_ready, 1'b1);
    check("abort_no_done", done, 1'b0);
    cyc();
    check("abort_no_done2", done, 1'b0);
    $display("abort checked");

    run_word("after_abort", 4'h9, 1'b0, 4'b1001, 1'b0, 1'b0);
    run_word("par0", 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
